// File: rtl/seg_scan_rx.sv
// rtl/seg_scan_rx.sv - multiplexed 7-segment display scanner capturing a 4-digit BCD frame (optional dp capture: SEG_DP_EN)
module seg_scan_rx #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  dig_en,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

`ifdef SEG_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif

    localparam logic [7:0] ACC_CNT = 8'(STABLE_CYC - 2);
    localparam logic [7:0] SAT_CNT = 8'(STABLE_CYC);

    typedef enum logic {COLLECT, COMMIT} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] seg_s, seg_p;
    logic [3:0]    en_s, en_p;
    logic [7:0]    cnt, cnt_nx;
    logic [3:0]    seen;
    logic [15:0]   slot;
    logic          same, accept, load;
    logic [3:0]    val;

`ifdef SEG_DP_EN
    logic [3:0] dps, dp_q;
    assign dp = dp_q;
`else
    logic unused_dp;
    assign unused_dp = seg[0];
    assign dp = 4'b0;
`endif

    function automatic logic [3:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 4'd0;
            7'b0011111: decode = 4'd1;
            7'b0100100: decode = 4'd2;
            7'b0001100: decode = 4'd3;
            7'b0011010: decode = 4'd4;
            7'b1001000: decode = 4'd5;
            7'b1000000: decode = 4'd6;
            7'b0011101: decode = 4'd7;
            7'b0000000: decode = 4'd8;
            7'b0001000: decode = 4'd9;
            default:    decode = 4'hF;
        endcase
    endfunction

    // A run counts only while the registered sample repeats and selects exactly one position.
    always_comb begin
        same   = (seg_s == seg_p) && (en_s == en_p) &&
                 (en_s != 4'b0) && ((en_s & (en_s - 4'd1)) == 4'b0);
        cnt_nx = 8'd0;
        if (same)
            cnt_nx = (cnt < SAT_CNT) ? cnt + 8'd1 : cnt;
        accept = same && (cnt == ACC_CNT);
        val    = decode(seg_s[SW-1 -: 7]);
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            COLLECT: if (seen == 4'b1111) state_nx = COMMIT;
            COMMIT: begin
                state_nx = COLLECT;
                load     = !out_valid || out_ready;
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s     <= '1;
            seg_p     <= '1;
            en_s      <= 4'b0;
            en_p      <= 4'b0;
            cnt       <= 8'd0;
            seen      <= 4'b0;
            slot      <= 16'hFFFF;
            digits    <= 16'hFFFF;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef SEG_DP_EN
            dps       <= 4'b0;
            dp_q      <= 4'b0;
`endif
        end else begin
            seg_p <= seg_s;
            seg_s <= seg[7 -: SW];
            en_p  <= en_s;
            en_s  <= dig_en;
            cnt   <= cnt_nx;

            // The commit cycle starts a fresh frame, but an accept landing in it is kept.
            if (state == COMMIT)
                seen <= accept ? en_s : 4'b0;
            else if (accept)
                seen <= seen | en_s;

            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    if (en_s[i]) begin
                        slot[4*i +: 4] <= val;
`ifdef SEG_DP_EN
                        dps[i] <= !seg_s[0];
`endif
                    end
                end
            end

            if (load) begin
                digits    <= slot;
                out_valid <= 1'b1;
`ifdef SEG_DP_EN
                dp_q      <= dps;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == COMMIT && !load)
                overrun <= 1'b1;
        end
    end

endmodule

// File: doc/seg_scan_rx.md
SEG_SCAN_RX -- requirements
Module: seg_scan_rx

Interface
REQ-001 Parameter STABLE_CYC, default 4, range 2..255: consecutive identical samples needed to accept a digit.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg  input  8  active-low segment bus, bit7..bit1 = segment pattern, bit0 = decimal point.
REQ-005 dig_en  input  4  active-high digit select; bit i selects display position i.
REQ-006 digits  output  16  captured frame, BCD; digits[4i+3:4i] = position i; 4'hF = invalid pattern.
REQ-007 dp  output  4  captured decimal points, active-high, bit i = position i.
REQ-008 out_valid  output  1  frame available in digits/dp.
REQ-009 out_ready  input  1  consumer accepts frame when out_valid && out_ready at a rising edge.
REQ-010 overrun  output  1  sticky: a completed frame was dropped.

Function
REQ-011 seg and dig_en are registered once (sample stage) before any comparison; no other synchronisation.
REQ-012 Stability counter clears to 0 when the sampled {seg,dig_en} differs from the previous sample or dig_en is not one-hot; otherwise it increments, saturating at STABLE_CYC.
REQ-013 A digit is accepted exactly once per stable run, in the cycle the counter reaches STABLE_CYC-1, i.e. STABLE_CYC consecutive identical samples.
REQ-014 Constant one-hot inputs sampled from edge T are written into the digit slot at edge T+STABLE_CYC.
REQ-015 Decode of seg[7:1] (pattern -> value): 0000001->0, 0011111->1, 0100100->2, 0001100->3, 0011010->4, 1001000->5, 1000000->6, 0011101->7, 0000000->8, 0001000->9; any other pattern -> 4'hF.
REQ-016 Accept writes the slot of the selected position and sets its seen bit; re-accepting a seen position overwrites the slot.
REQ-017 States: COLLECT (seen != 4'b1111) and COMMIT (one cycle, entered the edge after seen becomes 4'b1111).
REQ-018 In COMMIT: if out_valid is 0, or out_valid && out_ready in that cycle, slots load into digits/dp and out_valid is 1 the next cycle; otherwise the frame is dropped, outputs are unchanged, and overrun is set.
REQ-019 COMMIT always clears seen and returns to COLLECT; an accept occurring in the COMMIT cycle is recorded into the new frame.
REQ-020 out_valid falls the edge after out_valid && out_ready unless REQ-018 reloads in the same cycle.
REQ-021 digits/dp remain stable while out_valid is 1.
REQ-022 dig_en all-zero or multi-hot never accepts and never alters slots.

Reset
REQ-023 rst held at an edge: digits=16'hFFFF, dp=4'b0, out_valid=0, overrun=0, seen=0, counter=0, sample registers=all ones for seg and 0 for dig_en, state COLLECT.
REQ-024 rst mid-frame discards partial slots; accepting resumes on the first edge after rst deasserts with a fresh stability run.
REQ-025 overrun is cleared only by rst.

Configuration
REQ-026 Macro SEG_DP_EN defined: seg[0]=0 on accept stores dp bit 1 for that position; dp output reflects committed frame.
REQ-027 SEG_DP_EN undefined: seg[0] is ignored for decode and stability comparison, dp output is constant 4'b0, no dp storage flops.

Verification
REQ-028 Drive positions 0..3 with patterns for 1,2,3,4 (seg 8'h3F, 8'h49, 8'h19, 8'h35), each 6 cycles, out_ready=1 -> digits=16'h4321, out_valid high one cycle.
REQ-029 Position 2 held only STABLE_CYC-1 cycles, then switched -> no accept; frame completes only after position 2 is held >= STABLE_CYC cycles.
REQ-030 Position 1 driven seg=8'hFF -> digits[7:4]=4'hF in committed frame.
REQ-031 Two complete frames with out_ready=0 -> first frame retained, overrun=1; raise out_ready -> out_valid falls the next edge.
REQ-032 rst asserted after two positions accepted -> all outputs at reset values; the next full frame decodes correctly.
REQ-033 SEG_DP_EN defined, position 3 seg=8'h02 (digit 0, dp on) -> digits[15:12]=0, dp[3]=1; undefined -> dp=4'b0.
